// File: rtl/ro_puf_pkg.sv
// Shared types for the ring-oscillator PUF measurement path.
// Imported by the pair counter, its edge counters and the response collector.
package ro_puf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        COUNT,
        DONE
    } state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 16;

    typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/ro_edge_counter.sv
// One RO input: synchroniser, rising-edge detect and saturating counter.
// The sync/prev chain runs in every state; en only gates the counter.
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   rise;
    logic                   full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], ro};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~prev;
    assign full = &cnt;

    // A rise that would wrap the counter is dropped and flagged instead.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (en && rise) begin
            if (full) begin
                sat <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ro_pair_counter.sv
// RO pair measurement: settle, count both ROs over a gate window,
// then compare the counts into one response bit.
module ro_pair_counter
    import ro_puf_pkg::*;
#(
    parameter int GATE_W      = 16,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ro_a_i,
    input  logic              ro_b_i,
    input  logic [GATE_W-1:0] gate_cycles_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  cnt_a_o,
    output logic [CNT_W-1:0]  cnt_b_o,
    output logic              resp_o,
    output logic              tie_o,
    output logic              sat_o
);

    localparam int SET_W = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SYNC_STAGES);

    state_t            state;
    state_t            state_nx;
    logic [GATE_W-1:0] gate_left;
    logic [SET_W-1:0]  settle_cnt;
    logic              accept;
    logic              count_en;
    logic              sat_a;
    logic              sat_b;
    logic              gt;
    logic              eq;
    logic              resp_q;
    logic              tie_q;

    assign accept   = (state == IDLE) && start_i;
    assign count_en = (state == COUNT);

    ro_edge_counter #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W)
    ) u_cnt_a (
        .clk  (clk),
        .rst_n(rst_n),
        .ro   (ro_a_i),
        .clr  (accept),
        .en   (count_en),
        .cnt  (cnt_a_o),
        .sat  (sat_a)
    );

    ro_edge_counter #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W)
    ) u_cnt_b (
        .clk  (clk),
        .rst_n(rst_n),
        .ro   (ro_b_i),
        .clr  (accept),
        .en   (count_en),
        .cnt  (cnt_b_o),
        .sat  (sat_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SET_LAST) begin
                    state_nx = (gate_left == '0) ? DONE : COUNT;
                end
            end
            COUNT: begin
                if (gate_left == GATE_W'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gate_left  <= '0;
            settle_cnt <= '0;
            resp_q     <= 1'b0;
            tie_q      <= 1'b0;
        end else if (accept) begin
            gate_left  <= gate_cycles_i;
            settle_cnt <= '0;
            resp_q     <= 1'b0;
            tie_q      <= 1'b0;
        end else begin
            if (state == SETTLE) begin
                settle_cnt <= settle_cnt + SET_W'(1);
            end
            if (state == COUNT) begin
                gate_left <= gate_left - GATE_W'(1);
            end
            if (state == DONE) begin
                resp_q <= gt;
                tie_q  <= eq;
            end
        end
    end

    assign gt = (cnt_a_o > cnt_b_o);
    assign eq = (cnt_a_o == cnt_b_o);

    // The last COUNT edge lands in the counters on DONE entry, so the
    // DONE cycle compares live and the holding registers take over after.
    assign resp_o = (state == DONE) ? gt : resp_q;
    assign tie_o  = (state == DONE) ? eq : tie_q;
    assign sat_o  = sat_a | sat_b;
    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE);

endmodule
